// File: rtl/j_snd_pkg.sv
// j_snd_pkg: shared mode constants, transmitter state type and frame sizing helpers
package j_snd_pkg;
    localparam logic MODE_I2S = 1'b0;
    localparam logic MODE_LJ  = 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic int frame_bits(int dw, int nch);
        return dw * nch;
    endfunction

    function automatic int level_bits(int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/j_snd_fifo.sv
// j_snd_fifo: power-of-two frame FIFO with full/empty flags and occupancy count
module j_snd_fifo
    import j_snd_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [W-1:0]                 wr_data,
    output logic [W-1:0]                 rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [level_bits(DEPTH)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_bits(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_wr, do_rd;

    // A pop never frees space for a write in the same cycle: full gates writes alone.
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            level <= level + LW'(do_wr) - LW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wr_data;
    end
endmodule

// File: rtl/j_i2s_tx_mc.sv
// j_i2s_tx_mc: multichannel I2S / left-justified transmitter fed by a frame FIFO
module j_i2s_tx_mc
    import j_snd_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NCH   = 2,
    parameter int DEPTH = 4,
    parameter int DIV   = 4
) (
    input  logic                         sys_clk,
    input  logic                         xresetil,
    input  logic                         enable,
    input  logic                         mode,
    input  logic                         wr_en,
    input  logic [NCH*DW-1:0]            wr_data,
    output logic                         wr_ready,
    output logic                         xsck,
    output logic                         xws,
    output logic                         xi2stxd,
    output logic [NCH*DW-1:0]            snd_out,
    output logic                         snd_en,
    output logic [level_bits(DEPTH)-1:0] level,
    output logic                         underflow
);
    localparam int FB = frame_bits(DW, NCH);
    localparam int BW = $clog2(FB);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    state_t        state;
    logic [1:0]    rst_sync;
    logic [CW-1:0] div_cnt;
    logic [BW-1:0] bit_idx, nxt_idx;
    logic [FB-1:0] sh, fifo_q, ser, frame;
    logic          fifo_full, fifo_empty, mode_q;
    logic          tc, shift_ev, last, start, load, pop, drain_end;

    j_snd_fifo #(.W(FB), .DEPTH(DEPTH)) u_fifo (
        .clk(sys_clk), .rst_n(xresetil), .wr_en(wr_en), .rd_en(pop), .wr_data(wr_data),
        .rd_data(fifo_q), .full(fifo_full), .empty(fifo_empty), .level(level)
    );

    // Channel 0 goes out first, so it lands at the top of the shift register.
    for (genvar c = 0; c < NCH; c++) begin : g_ser
        assign ser[(NCH-1-c)*DW +: DW] = fifo_q[c*DW +: DW];
    end

    function automatic logic ws_of(logic m, logic [BW-1:0] b);
        logic [BW-1:0] i;
        i = (m == MODE_LJ) ? b : ((b == BW'(FB - 1)) ? '0 : b + 1'b1);
        return i >= BW'(FB / 2);
    endfunction

    assign tc        = div_cnt == CW'(DIV - 1);
    assign shift_ev  = state != IDLE && tc && xsck;
    assign last      = bit_idx == BW'(FB - 1);
    assign nxt_idx   = last ? '0 : bit_idx + 1'b1;
    assign start     = state == IDLE && enable && rst_sync[1];
    assign load      = start || (shift_ev && last && (state == RUN || enable));
    assign drain_end = shift_ev && last && state == DRAIN && !enable;
    assign pop       = load && !fifo_empty;
    assign frame     = fifo_empty ? '0 : ser;
    assign wr_ready  = !fifo_full;

    always_ff @(posedge sys_clk or negedge xresetil) begin
        if (!xresetil) begin
            state     <= IDLE;
            rst_sync  <= '0;
            div_cnt   <= '0;
            bit_idx   <= '0;
            sh        <= '0;
            mode_q    <= MODE_I2S;
            xsck      <= 1'b0;
            xws       <= 1'b0;
            xi2stxd   <= 1'b0;
            snd_out   <= '0;
            snd_en    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
            snd_en   <= pop;
            if (pop) snd_out <= fifo_q;
            if (load && fifo_empty) underflow <= 1'b1;
            div_cnt <= (state == IDLE || tc) ? '0 : div_cnt + 1'b1;
            xsck    <= state != IDLE && (xsck ^ tc);
            // A load presents bit 0 at once; every later bit follows a falling xsck.
            if (load) begin
                mode_q  <= mode;
                sh      <= frame << 1;
                xi2stxd <= frame[FB-1];
                xws     <= ws_of(mode, BW'(0));
                bit_idx <= '0;
            end else if (shift_ev) begin
                sh      <= sh << 1;
                xi2stxd <= sh[FB-1];
                xws     <= ws_of(mode_q, nxt_idx);
                bit_idx <= nxt_idx;
            end
            if (start) state <= RUN;
            else if (drain_end) begin
                state   <= IDLE;
                xws     <= 1'b0;
                xi2stxd <= 1'b0;
            end
            else if (state == RUN && !enable) state <= DRAIN;
            else if (state == DRAIN && enable) state <= RUN;
        end
    end
endmodule

// File: doc/j_i2s_tx_mc.md
J_I2S_TX_MC -- requirements
Module: j_i2s_tx_mc

Interface
REQ-001 Parameter DW, default 16: sample width in bits, 8..32.
REQ-002 Parameter NCH, default 2: channels per frame, even, 2..8.
REQ-003 Parameter DEPTH, default 4: FIFO depth in frames, a power of two, at least 2.
REQ-004 Parameter DIV, default 4: sys_clk cycles per xsck half-period, at least 1.
REQ-005 sys_clk  in  1: the only clock; all logic is rising-edge.
REQ-006 xresetil  in  1: asynchronous, active-low reset.
REQ-007 enable  in  1: run the serial link.
REQ-008 mode  in  1: 0 = I2S (one-bit WS lead), 1 = left-justified.
REQ-009 wr_en  in  1: frame write strobe.
REQ-010 wr_data  in  NCH*DW: frame; channel 0 in the LSBs.
REQ-011 wr_ready  out  1: FIFO not full.
REQ-012 xsck  out  1: bit clock.
REQ-013 xws  out  1: word select.
REQ-014 xi2stxd  out  1: serial data, MSB first.
REQ-015 snd_out  out  NCH*DW: the frame currently being transmitted.
REQ-016 snd_en  out  1: one-cycle pulse when snd_out updates.
REQ-017 level  out  clog2(DEPTH)+1: FIFO occupancy.
REQ-018 underflow  out  1: sticky; cleared only by reset.

Function
REQ-019 A write is accepted when wr_en=1 and wr_ready=1; a write with wr_ready=0 is dropped and does not change the FIFO.
REQ-020 When the FIFO is full, wr_ready stays 0 even if a pop happens in the same cycle; there is no write-through.
REQ-021 The FSM has three states: IDLE, RUN and DRAIN.
REQ-022 IDLE -> RUN on enable=1.
REQ-023 RUN -> DRAIN on enable=0; DRAIN -> IDLE after the last bit of the current frame; DRAIN -> RUN if enable returns to 1 before that last bit.
REQ-024 In IDLE, xsck=0, xws=0, xi2stxd=0 and the divider is held at 0.
REQ-025 In RUN and DRAIN, a divider counts 0..DIV-1 and xsck toggles at terminal count, giving a period of 2*DIV cycles.
REQ-026 A shift event is the cycle in which xsck toggles 1->0; xws and xi2stxd change only on shift events.
REQ-027 FB = NCH*DW bits per frame; the bit index b runs 0..FB-1 and wraps to 0 after FB-1.
REQ-028 Frame load occurs on the IDLE->RUN transition and on every shift event with b=FB-1 while in RUN.
REQ-029 Frame load, FIFO non-empty: pop one frame, copy it to snd_out and pulse snd_en in the same cycle.
REQ-030 Frame load, FIFO empty: transmit an all-zero frame, leave snd_out unchanged, do not pulse snd_en, and set underflow.
REQ-031 A pop and a write in the same cycle on an empty FIFO count as underflow; the written frame is stored.
REQ-032 Bit b carries bit DW-1-(b mod DW) of channel b/DW.
REQ-033 xws = 0 for channels 0..NCH/2-1 and 1 for the remaining channels.
REQ-034 In mode 0, xws for bit b is computed from (b+1) mod FB, so it leads the data by one bit.
REQ-035 In mode 1, xws for bit b is computed from b.
REQ-036 mode is sampled only at frame load; a change mid-frame takes effect at the next frame.
REQ-037 level = writes - pops, kept in range 0..DEPTH.

Reset
REQ-038 While xresetil=0, the FSM is in IDLE and the FIFO is empty.
REQ-039 While xresetil=0, level=0, wr_ready=1, xsck=0, xws=0, xi2stxd=0, snd_out=0, snd_en=0 and underflow=0.
REQ-040 Reset asserted mid-frame aborts the frame immediately; no partial frame resumes after release.
REQ-041 Reset release is synchronised internally (two-flop) before the FSM leaves IDLE.

Structure
REQ-042 Shared package j_snd_pkg holds the mode constants (MODE_I2S=0, MODE_LJ=1), the FSM state enum and the FB/width helper functions.
REQ-043 The FIFO is a sub-module, j_snd_fifo, parametrised by width and DEPTH, with full, empty and level outputs.
REQ-044 The top level contains the divider, the FSM, the shift register and the WS generation.

Verification (DW=16, NCH=2, DIV=2 unless stated; xsck period 4 cycles, frame 128 cycles)
REQ-045 Write 0x8001_C003, then enable=1 -> snd_en pulses once. The channel-0 bits (0xC003) come out first, MSB first, followed by the channel-1 bits (0x8001). In mode 0, xws rises one xsck before the channel-1 MSB.
REQ-046 mode=1 with the same frame -> xws rises on the same shift event as the channel-1 MSB.
REQ-047 enable=1 with the FIFO empty -> 32 zero bits are sent, underflow=1, and snd_en never pulses.
REQ-048 Five writes back-to-back with DEPTH=4 -> the fifth write is dropped and level=4. Once a frame load begins, a simultaneous write while full is still refused.
REQ-049 enable=0 at b=10 -> the frame finishes (bits 11..31 are sent) and the FSM returns to IDLE with xsck=0. No frame is lost from the FIFO.
REQ-050 Reset pulsed at b=20 -> all outputs go to 0 the next cycle and level=0. After release and enable=1, the next frame starts at b=0. Regression also runs with DW=24, NCH=4, DIV=1.
